// File: rtl/uart_tx_frame.sv
// UART transmitter: sends one latched word as start, LSB-first data,
// optional even/odd parity and one stop bit, one bit per baud clock.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    // STOP accepts like IDLE so back-to-back frames have no idle gap
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        case (state_q)
            IDLE, STOP: begin
                if (DATA_VALID) begin
                    state_d   = START;
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: state_d = STOP;
            default: state_d = IDLE;
        endcase
    end

    // Line value is decoded from the next state so TX_OUT/Busy come straight off flops
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        case (state_d)
            IDLE:    busy_d = 1'b0;
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[cnt_d];
            PARITY:  tx_d = (^data_d) ^ par_typ_d;
            STOP:    tx_d = 1'b1;
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame; expected frames are hand-built as
// {stop, [parity], data, start} with bit 0 being the first bit on the line.
module tb_uart_tx_frame;

    logic       CLK;
    logic       RST_n;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int nvec = 0;
    int nerr = 0;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".tx"}, {31'd0, TX_OUT}, 32'd1);
        chk({tag, ".busy"}, {31'd0, Busy}, 32'd0);
    endtask

    // Called at a negedge: the next posedge accepts, then each following negedge is one line bit.
    task automatic xmit(input string tag, input logic [7:0] d, input logic pen, input logic ptyp,
                        input logic [10:0] exp, input int len, input int glitch_at, input int abort_at);
        DATA_VALID = 1'b1;
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (i == glitch_at) begin
                DATA_VALID = 1'b1;
                P_DATA     = 8'hFF;
                PAR_EN     = ~PAR_EN;
            end
            if (i == glitch_at + 1) DATA_VALID = 1'b0;
            chk($sformatf("%s.b%0d.tx", tag, i), {31'd0, TX_OUT}, {31'd0, exp[i]});
            chk($sformatf("%s.b%0d.busy", tag, i), {31'd0, Busy}, 32'd1);
            if (i == abort_at) begin
                #2 RST_n = 1'b0;
                #1 chk_idle({tag, ".async"});
                DATA_VALID = 1'b1;
                @(negedge CLK);
                chk_idle({tag, ".rstwins"});
                DATA_VALID = 1'b0;
                RST_n      = 1'b1;
                return;
            end
            @(negedge CLK);
        end
        chk_idle({tag, ".end0"});
        @(negedge CLK);
        chk_idle({tag, ".end1"});
    endtask

    logic [19:0] exp20;

    initial begin
        RST_n      = 1'b0;
        DATA_VALID = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        repeat (2) @(negedge CLK);
        chk_idle("reset");
        RST_n = 1'b1;
        @(negedge CLK);
        chk_idle("post_reset");

        xmit("a5",      8'hA5, 1'b0, 1'b0, 11'b0_1_10100101_0, 10, -1, -1);
        xmit("0f_even", 8'h0F, 1'b1, 1'b0, 11'b1_0_00001111_0, 11, -1, -1);
        xmit("0f_odd",  8'h0F, 1'b1, 1'b1, 11'b1_1_00001111_0, 11, -1, -1);
        xmit("01_even", 8'h01, 1'b1, 1'b0, 11'b1_1_00000001_0, 11, -1, -1);

        DATA_VALID = 1'b1;
        P_DATA     = 8'h55;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        exp20      = 20'b1_10101010_0_1_01010101_0;
        @(negedge CLK);
        for (int i = 0; i < 20; i++) begin
            if (i == 1) P_DATA = 8'hAA;
            if (i == 12) DATA_VALID = 1'b0;
            chk($sformatf("b2b.b%0d.tx", i), {31'd0, TX_OUT}, {31'd0, exp20[i]});
            chk($sformatf("b2b.b%0d.busy", i), {31'd0, Busy}, 32'd1);
            @(negedge CLK);
        end
        chk_idle("b2b.end0");
        @(negedge CLK);
        chk_idle("b2b.end1");

        xmit("3c_glitch", 8'h3C, 1'b0, 1'b0, 11'b0_1_00111100_0, 10, 3, -1);
        PAR_EN = 1'b0;

        xmit("abort", 8'hA5, 1'b0, 1'b0, 11'b0_1_10100101_0, 10, -1, 4);
        for (int i = 0; i < 20; i++) begin
            chk_idle($sformatf("hold%0d", i));
            @(negedge CLK);
        end
        xmit("c3_odd", 8'hC3, 1'b1, 1'b1, 11'b1_1_11000011_0, 11, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter: serializes one parallel byte into a start/data/parity/stop frame on TX_OUT, one bit per CLK.
- CLK is the TX baud clock; the clock-divider and clock-gating logic outside this block provide it.
- It is the transmit-side counterpart of the UART receiver in the same UART subsystem.
- Frame format and parity options match the receiver's expectations: LSB-first, optional even/odd parity, one stop bit.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- CLK  input  1  TX baud clock; one line bit per cycle.
- RST_n  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel byte to send; sampled only on accept.
- DATA_VALID  input  1  request to send P_DATA; single-cycle or level.
- PAR_EN  input  1  1 = insert parity bit; sampled on accept.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.
- TX_OUT  output  1  serial line, registered; idle high.
- Busy  output  1  registered; high from start bit through stop bit.

Behaviour:
- Reset (async, RST_n low): state = IDLE, TX_OUT = 1, Busy = 0, shift register = 0, bit counter = 0, latched config = 0. All outputs take these values immediately on RST_n low, with no clock required.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept: in IDLE, a CLK edge with DATA_VALID = 1 latches P_DATA, PAR_EN and PAR_TYP.
  - The same edge enters START, so TX_OUT = 0 and Busy = 1 are visible one cycle after the accepting edge.
  - Latency from accept to start bit = 1 cycle.
- START lasts 1 cycle, then DATA with bit counter = 0.
- DATA lasts DATA_WIDTH cycles.
  - TX_OUT = latched data bit[counter], LSB first; counter increments each cycle.
  - After the cycle with counter = DATA_WIDTH-1, go to PARITY if latched PAR_EN = 1, else STOP.
- PARITY lasts 1 cycle.
  - TX_OUT = XOR-reduce(latched data) when even (PAR_TYP = 0).
  - TX_OUT = the inverse of that value when odd (PAR_TYP = 1).
- STOP lasts 1 cycle with TX_OUT = 1, Busy = 1.
  - On the edge ending STOP, if DATA_VALID = 1: accept new data and go directly to START (back-to-back, no idle gap, Busy stays 1).
  - Otherwise go to IDLE: TX_OUT = 1, Busy = 0.
- Frame length: 1 + DATA_WIDTH + PAR_EN + 1 cycles (10 or 11 for 8 bits).
- DATA_VALID in START, DATA or PARITY is ignored and not queued.
- Changes to P_DATA, PAR_EN or PAR_TYP mid-frame do not affect the frame in flight.
- TX_OUT is driven from a flop: no glitches, and no combinational path from any input to TX_OUT or Busy.
- Reset mid-frame: the line returns high at once and the partial frame is abandoned. After release, the block waits in IDLE for a fresh DATA_VALID.
- Simultaneous RST_n low and DATA_VALID: reset wins and nothing is accepted.

Test Plan:
1. Reset, DATA_VALID=1 for 1 cycle with P_DATA=0xA5, PAR_EN=0 -> TX_OUT from the next cycle = 0,1,0,1,0,0,1,0,1,1; then idle high with Busy=0; Busy high for exactly 10 cycles.
2. P_DATA=0x0F, PAR_EN=1, PAR_TYP=0 -> 0,1,1,1,1,0,0,0,0, parity 0, stop 1; Busy high 11 cycles.
3. Same as 2 with PAR_TYP=1 -> parity bit 1. Then P_DATA=0x01 with even parity -> parity bit 1.
4. DATA_VALID held high, P_DATA=0x55 then 0xAA, PAR_EN=0 -> two frames, 20 consecutive cycles with Busy=1; the second start bit immediately follows the first stop bit.
5. Accept 0x3C, then during the DATA state pulse DATA_VALID with P_DATA=0xFF and toggle PAR_EN -> frame still carries 0x3C with no parity; no second frame follows.
6. Assert RST_n low during the 4th data bit -> TX_OUT=1 and Busy=0 asynchronously. After release with DATA_VALID=0, the line stays high indefinitely. A new DATA_VALID then sends a complete correct frame.
